// File: rtl/aes128_round_ctrl_pkg.sv
// Shared state encoding, constants and the GF(2^8) doubling helper
// used by the AES-128 round sequencing controller.
package aes128_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } ctrl_state_e;

  localparam int         AES128_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_round_ctrl_if.sv
// Host handshake and datapath strobe bundle for the AES-128
// round controller; master is the controller side.
interface aes128_round_ctrl_if;
  import aes128_ctrl_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       abort;
  logic       dp_load;
  logic       dp_round_en;
  logic       dp_key_en;
  logic       dp_final;
  logic [7:0] rcon;
  logic [3:0] round_idx;
  logic       busy;

  modport master (
    input  in_valid,
    input  out_ready,
    input  abort,
    output in_ready,
    output out_valid,
    output dp_load,
    output dp_round_en,
    output dp_key_en,
    output dp_final,
    output rcon,
    output round_idx,
    output busy
  );

  modport slave (
    output in_valid,
    output out_ready,
    output abort,
    input  in_ready,
    input  out_valid,
    input  dp_load,
    input  dp_round_en,
    input  dp_key_en,
    input  dp_final,
    input  rcon,
    input  round_idx,
    input  busy
  );

endinterface

// File: rtl/aes128_round_ctrl_rcon.sv
// Round-constant register: reloads the initial constant or
// advances by one GF(2^8) doubling per key-expansion step.
module aes128_rcon_gen
  import aes128_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       init,
  input  logic       step,
  output logic [7:0] rcon
);

  // init wins so a cancelled block always restarts from 01
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcon <= RCON_INIT;
    end else if (init) begin
      rcon <= RCON_INIT;
    end else if (step) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 sequencer: accepts a block, strobes load and
// per-round commits into the datapath, then holds the result.
module aes128_round_ctrl
  import aes128_ctrl_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int ROUND_CYC = 1
) (
  input  logic                CLK,
  input  logic                RST,
  aes128_round_ctrl_if.master bus
);

  localparam logic [3:0] NR_L     = 4'(NR);
  localparam logic [1:0] SUB_LAST = 2'(ROUND_CYC - 1);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic [3:0]  round_q;
  logic [3:0]  round_d;
  logic [1:0]  sub_q;
  logic [1:0]  sub_d;
  logic        last;
  logic        commit;
  logic        rcon_init;
  logic        rcon_step;

  assign last   = (round_q == NR_L);
  assign commit = (state_q == ROUND) && (sub_q == SUB_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      round_q <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    sub_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
          round_d = '0;
        end else begin
          state_d = ROUND;
          round_d = 4'd1;
        end
      end
      ROUND: begin
        sub_d = commit ? 2'd0 : sub_q + 2'd1;
        if (commit && !last) begin
          round_d = round_q + 4'd1;
        end
        if (commit && last) begin
          state_d = DONE;
        end
        // a commit in the abort cycle still fires; only the
        // bookkeeping is dropped
        if (bus.abort) begin
          state_d = IDLE;
          round_d = '0;
          sub_d   = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  assign rcon_init = (state_d == IDLE) || (state_q == LOAD);
  assign rcon_step = commit && !last;

  aes128_rcon_gen u_rcon (
    .CLK  (CLK),
    .RST  (RST),
    .init (rcon_init),
    .step (rcon_step),
    .rcon (bus.rcon)
  );

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.dp_load     = (state_q == LOAD);
  assign bus.dp_round_en = commit;
  assign bus.dp_key_en   = commit;
  assign bus.dp_final    = (state_q == ROUND) && last;
  assign bus.round_idx   = round_q;

endmodule

// File: doc/aes128_round_ctrl.md
# aes128_round_ctrl

Sequencing controller for the iterative AES-128 encryption datapath. It accepts a block/key handshake, drives load, round-enable and final-round strobes plus the round constant to the state and key-expansion registers, and presents a result handshake. It sits between the host interface and the synthesized round datapath, which holds all state and key bits.

## Interface
- `NR`, default 10: number of AES rounds; fixed for AES-128.
- `ROUND_CYC`, default 1: cycles the datapath needs per round; legal range 1..4.
- `CLK`  in  1: single clock; everything is posedge.
- `RST`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: plaintext and key are present on the datapath inputs.
- `in_ready`  out  1: controller can accept a block.
- `out_valid`  out  1: ciphertext on the datapath output is valid.
- `out_ready`  in  1: consumer accepts the ciphertext.
- `abort`  in  1: synchronous cancel of the block in flight.
- `dp_load`  out  1: capture plaintext^key into the state register, and the key into the key register.
- `dp_round_en`  out  1: commit one round into the state register.
- `dp_key_en`  out  1: commit one key-expansion step into the key register.
- `dp_final`  out  1: the current round is the final round; the datapath bypasses MixColumns.
- `rcon`  out  8: round constant for the current key-expansion step.
- `round_idx`  out  4: current round number, 0..NR.
- `busy`  out  1: a block is in flight.

## Operation
- FSM states are IDLE, LOAD, ROUND and DONE. All outputs are Moore, decoded from registered state. There is no combinational input-to-output path.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, the next state is LOAD.
- LOAD: one cycle. `dp_load`=1 and `round_idx`=0. Next state is ROUND, with `round_idx`=1, `rcon`=8'h01 and sub-cycle counter `sub`=0.
- ROUND:
  - `sub` counts 0..ROUND_CYC-1.
  - On `sub`==ROUND_CYC-1, `dp_round_en`=`dp_key_en`=1 for exactly one cycle.
  - After that commit:
    - if `round_idx`<NR, `round_idx`+1 and `rcon`=xtime(`rcon`);
    - if `round_idx`==NR, the next state is DONE.
- `dp_final`=1 throughout ROUND when `round_idx`==NR.
- `rcon` sequence: 01,02,04,08,10,20,40,80,1B,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- DONE: `out_valid`=1 and held until `out_ready`. On `out_valid`&&`out_ready`, the next state is IDLE. `round_idx` holds NR.
- `busy`=1 in LOAD, ROUND and DONE.
- `abort` is sampled in LOAD and ROUND. When sampled, the next state is IDLE and `round_idx`=0. No `out_valid` is produced for that block.
- `abort` in DONE is ignored; the result must still be consumed.
- `abort` in the same cycle as a ROUND commit: strobes still fire that cycle, then the next state is IDLE.
- `in_valid` while not in IDLE is ignored and not queued.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, all `dp_*`=0, `rcon`=8'h01, `round_idx`=0, `busy`=0, `sub`=0.
- Reset is asynchronous. Asserting `RST` mid-block returns all outputs to reset values immediately, with no commit strobe.
- Handshake accepted at cycle T:
  - LOAD at T+1;
  - round r commits at T+1+r·ROUND_CYC;
  - `out_valid` first high at T+2+NR·ROUND_CYC.
  - With defaults, `out_valid` rises at T+12.
- Throughput: one block per NR·ROUND_CYC+3 cycles when `out_ready` is held high. After the DONE handshake the FSM goes to IDLE; there is no back-to-back accept.
- `dp_load`, `dp_round_en` and `dp_key_en` are single-cycle pulses and are mutually exclusive with `dp_load`.

## Structure
- Package `aes128_ctrl_pkg` holds:
  - the state enum (IDLE, LOAD, ROUND, DONE);
  - `AES128_NR`=10;
  - `RCON_INIT`=8'h01;
  - the xtime function.
- Sub-module `aes128_rcon_gen` is an 8-bit register with load-init and step-enable inputs, and applies xtime on step. It is reusable by the future decryption controller.
- The top level holds the FSM, the round counter and the `sub` counter.

## Test plan
- Reset then a single block, ROUND_CYC=1, `out_ready`=1. Handshake at T gives:
  - `dp_load` at T+1;
  - ten `dp_round_en` pulses at T+2..T+11;
  - `dp_final` only at T+11;
  - `out_valid` at T+12;
  - `rcon` matching the 01..36 sequence per round.
- ROUND_CYC=3: commits land at T+4, T+7, …, T+31, and `out_valid` rises at T+32.
- Backpressure: `out_ready`=0 for 5 cycles. `out_valid` holds, `in_ready` stays 0, and `in_valid` pulses are ignored. Release gives IDLE on the next cycle.
- `abort` on round 5's commit cycle: that commit fires, then the FSM is in IDLE with `round_idx`=0 and `rcon`=01. The next block runs a full, correct sequence.
- Asynchronous `RST` pulse mid-ROUND, between clock edges: outputs return to reset values before the next edge, and no strobes are seen afterward.
- `abort` held in DONE: `out_valid` stays high until `out_ready`.
